// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grant of one shared bus among N_MASTERS agents,
// with FRAME#/IRDY# ownership tracking, grant timeout and optional parking.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int OWNER_W     = 2,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_EN     = 1,
  parameter int PARK_MASTER = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] REQ_n,
  input  logic                 FRAME_n,
  input  logic                 IRDY_n,
  output logic [N_MASTERS-1:0] GNT_n,
  output logic [OWNER_W-1:0]   OWNER,
  output logic                 OWNER_VALID,
  output logic                 TIMEOUT,
  output logic                 PROT_ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t             state;
  logic [OWNER_W-1:0] ptr;
  logic [7:0]         timer;
  logic               parked;

  logic               any_req;
  logic               owner_req;
  logic               bus_idle;
  logic [OWNER_W-1:0] winner;

  // Pointer advances modulo N_MASTERS, not modulo 2**OWNER_W.
  function automatic logic [OWNER_W-1:0] ptr_incr(input logic [OWNER_W-1:0] p);
    return (int'(p) >= N_MASTERS - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OWNER_W-1:0] find_winner(input logic [N_MASTERS-1:0] req_n,
                                                      input logic [OWNER_W-1:0]   start);
    logic [OWNER_W-1:0]   w;
    logic                 found;
    logic [N_MASTERS-1:0] onehot;
    int                   idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = int'(start) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      onehot = N_MASTERS'(1) << idx;
      if (!found && (|(~req_n & onehot))) begin
        w     = OWNER_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [N_MASTERS-1:0] grant_of(input logic [OWNER_W-1:0] idx);
    return ~(N_MASTERS'(1) << idx);
  endfunction

  assign any_req   = |(~REQ_n);
  assign owner_req = |(~REQ_n & (N_MASTERS'(1) << OWNER));
  assign bus_idle  = FRAME_n && IRDY_n;
  assign winner    = find_winner(REQ_n, ptr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      parked      <= 1'b0;
      GNT_n       <= '1;
      OWNER       <= '0;
      OWNER_VALID <= 1'b0;
      TIMEOUT     <= 1'b0;
      PROT_ERR    <= 1'b0;
    end else begin
      TIMEOUT  <= 1'b0;
      PROT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (!FRAME_n) begin
            // A transaction started in IDLE is legal only from the parked agent.
            state  <= BUSY;
            GNT_n  <= '1;
            parked <= 1'b0;
            if (parked) begin
              OWNER       <= OWNER_W'(PARK_MASTER);
              OWNER_VALID <= 1'b1;
              ptr         <= ptr_incr(OWNER_W'(PARK_MASTER));
            end else begin
              PROT_ERR <= 1'b1;
            end
          end else if (any_req) begin
            state  <= GRANTED;
            GNT_n  <= grant_of(winner);
            OWNER  <= winner;
            timer  <= '0;
            parked <= 1'b0;
          end else if (PARK_EN != 0) begin
            GNT_n  <= grant_of(OWNER_W'(PARK_MASTER));
            OWNER  <= OWNER_W'(PARK_MASTER);
            parked <= 1'b1;
          end else begin
            GNT_n  <= '1;
            parked <= 1'b0;
          end
        end
        GRANTED: begin
          if (!FRAME_n) begin
            state       <= BUSY;
            GNT_n       <= '1;
            OWNER_VALID <= 1'b1;
            ptr         <= ptr_incr(OWNER);
          end else if (!owner_req) begin
            state <= IDLE;
            GNT_n <= '1;
          end else if (timer == 8'(GNT_TIMEOUT - 1)) begin
            state   <= IDLE;
            GNT_n   <= '1;
            TIMEOUT <= 1'b1;
            ptr     <= ptr_incr(OWNER);
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        BUSY: begin
          GNT_n <= '1;
          if (bus_idle) begin
            state       <= TURN;
            OWNER_VALID <= 1'b0;
          end
        end
        TURN: begin
          GNT_n <= '1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          GNT_n <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: a parking instance and a non-parking instance
// share the bus inputs; expected grant vectors are hand-computed.
module tb_pci_bus_arbiter;
  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ_n;
  logic       FRAME_n;
  logic       IRDY_n;

  logic [3:0] GNT_n,    np_gnt_n;
  logic [1:0] OWNER,    np_owner;
  logic       OWNER_VALID, np_owner_valid;
  logic       TIMEOUT,  np_timeout;
  logic       PROT_ERR, np_prot_err;

  int checks   = 0;
  int failures = 0;
  int cnt;

  pci_bus_arbiter #(.N_MASTERS(4), .OWNER_W(2), .GNT_TIMEOUT(16), .PARK_EN(1), .PARK_MASTER(0)) dut (
    .CLK(CLK), .RST(RST), .REQ_n(REQ_n), .FRAME_n(FRAME_n), .IRDY_n(IRDY_n),
    .GNT_n(GNT_n), .OWNER(OWNER), .OWNER_VALID(OWNER_VALID), .TIMEOUT(TIMEOUT), .PROT_ERR(PROT_ERR)
  );

  pci_bus_arbiter #(.N_MASTERS(4), .OWNER_W(2), .GNT_TIMEOUT(16), .PARK_EN(0), .PARK_MASTER(0)) dut_np (
    .CLK(CLK), .RST(RST), .REQ_n(REQ_n), .FRAME_n(FRAME_n), .IRDY_n(IRDY_n),
    .GNT_n(np_gnt_n), .OWNER(np_owner), .OWNER_VALID(np_owner_valid), .TIMEOUT(np_timeout),
    .PROT_ERR(np_prot_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; REQ_n = 4'b1111; FRAME_n = 1'b1; IRDY_n = 1'b1;
    step(); step();
    check("rst_gnt", GNT_n, 4'b1111);
    check("rst_owner", OWNER, 2'd0);
    check("rst_ov", OWNER_VALID, 1'b0);
    check("rst_timeout", TIMEOUT, 1'b0);
    check("rst_prot_err", PROT_ERR, 1'b0);
    check("np_rst_gnt", np_gnt_n, 4'b1111);
    RST = 1'b0;

    step();
    check("park_gnt", GNT_n, 4'b1110);
    check("park_owner", OWNER, 2'd0);
    check("np_idle_gnt", np_gnt_n, 4'b1111);

    // round robin: agents 1 and 3 request, ptr=0
    REQ_n = 4'b0101; step();
    check("rr_gnt", GNT_n, 4'b1101);
    check("rr_owner", OWNER, 2'd1);
    FRAME_n = 1'b0; step();
    check("busy_gnt", GNT_n, 4'b1111);
    check("busy_ov", OWNER_VALID, 1'b1);
    IRDY_n = 1'b0; step();
    check("busy_hold_gnt", GNT_n, 4'b1111);
    FRAME_n = 1'b1; IRDY_n = 1'b1; step();
    check("turn_ov", OWNER_VALID, 1'b0);
    check("turn_gnt", GNT_n, 4'b1111);
    step();
    check("turn_idle_gnt", GNT_n, 4'b1111);
    step();
    check("rr2_gnt", GNT_n, 4'b0111);
    check("rr2_owner", OWNER, 2'd3);

    REQ_n = 4'b1111; step();
    check("wd3_gnt", GNT_n, 4'b1111);
    step();
    check("repark_gnt", GNT_n, 4'b1110);

    // timeout: agent 2 never starts a transaction
    REQ_n = 4'b1011; step();
    check("to_gnt", GNT_n, 4'b1011);
    REQ_n = 4'b0011;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (GNT_n[2] == 1'b0) cnt++;
      else break;
    end
    check("to_len", cnt, 16);
    check("to_pulse", TIMEOUT, 1'b1);
    check("to_rel_gnt", GNT_n, 4'b1111);
    step();
    check("to_next_gnt", GNT_n, 4'b0111);
    check("to_next_owner", OWNER, 2'd3);
    check("to_pulse_end", TIMEOUT, 1'b0);

    // pointer wraps 3 -> 0 after agent 3 owns the bus
    REQ_n = 4'b0110; FRAME_n = 1'b0; step();
    check("wrap_ov", OWNER_VALID, 1'b1);
    FRAME_n = 1'b1; step(); step(); step();
    check("wrap_gnt", GNT_n, 4'b1110);
    check("wrap_owner", OWNER, 2'd0);
    REQ_n = 4'b1111; step();
    check("wrap_wd_gnt", GNT_n, 4'b1111);
    step();
    check("park2_gnt", GNT_n, 4'b1110);

    // parked agent 0 starts a transaction
    FRAME_n = 1'b0; step();
    check("pk_busy_gnt", GNT_n, 4'b1111);
    check("pk_owner", OWNER, 2'd0);
    check("pk_ov", OWNER_VALID, 1'b1);
    check("pk_prot_err", PROT_ERR, 1'b0);
    check("np_pk_prot_err", np_prot_err, 1'b1);
    check("np_pk_ov", np_owner_valid, 1'b0);
    FRAME_n = 1'b1; step(); step(); step();
    check("park3_gnt", GNT_n, 4'b1110);

    // withdraw before FRAME keeps the pointer
    REQ_n = 4'b1101; step();
    check("wd_gnt", GNT_n, 4'b1101);
    REQ_n = 4'b1111; step();
    check("wd_rel_gnt", GNT_n, 4'b1111);
    check("wd_owner", OWNER, 2'd1);
    REQ_n = 4'b0101; step();
    check("wd_regnt", GNT_n, 4'b1101);
    check("wd_reowner", OWNER, 2'd1);

    // asynchronous reset in the middle of BUSY
    FRAME_n = 1'b0; step();
    check("ar_pre_ov", OWNER_VALID, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("ar_gnt", GNT_n, 4'b1111);
    check("ar_ov", OWNER_VALID, 1'b0);
    check("ar_owner", OWNER, 2'd0);
    FRAME_n = 1'b1; REQ_n = 4'b1111;
    step();
    RST = 1'b0;

    // FRAME in IDLE with nobody granted
    step();
    check("np_idle2_gnt", np_gnt_n, 4'b1111);
    FRAME_n = 1'b0; step();
    check("np_prot_err", np_prot_err, 1'b1);
    check("np_pe_ov", np_owner_valid, 1'b0);
    check("np_pe_gnt", np_gnt_n, 4'b1111);
    step();
    check("np_pe_pulse_end", np_prot_err, 1'b0);
    FRAME_n = 1'b1; step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
